// File: rtl/pll_reset_sequencer.sv
// Qualifies a synchronized PLL lock flag, then releases a bank of domain resets in order.
// Any loss of lock after release has begun re-asserts every reset and bumps the loss counter.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int NUM_RESETS         = 3,
   parameter int STAGE_GAP_CYCLES   = 16
) (
   input  logic                  clk_in,
   input  logic                  reset_n,
   input  logic                  pll_locked,
   input  logic                  clear_lost,
   output logic [NUM_RESETS-1:0] rst_out_n,
   output logic                  ready,
   output logic                  lock_lost,
   output logic [7:0]            lost_count,
   output logic [1:0]            dbg_state
);

   localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int GW = (STAGE_GAP_CYCLES > 1) ? $clog2(STAGE_GAP_CYCLES) : 1;
   localparam int IW = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q, sync_d;
   logic [SW-1:0]           stab_q, stab_d;
   logic [GW-1:0]           gap_q, gap_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [NUM_RESETS-1:0]   rst_q, rst_d;
   logic                    ready_q, ready_d;
   logic                    lost_q, lost_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    lock_s;
   logic                    loss;

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], pll_locked};
      state_d = state_q;
      stab_d  = stab_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      lost_d  = lost_q;
      cnt_d   = cnt_q;
      loss    = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               stab_d  = '0;
            end
         end
         STABLE: begin
            // A drop here is only a failed qualification, never a counted loss.
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (stab_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
               state_d = RELEASE;
               gap_d   = '0;
               idx_d   = '0;
            end else begin
               stab_d = stab_q + SW'(1);
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               loss = 1'b1;
            end else if (gap_q == GW'(STAGE_GAP_CYCLES - 1)) begin
               rst_d = rst_q | (NUM_RESETS'(1) << idx_q);
               gap_d = '0;
               idx_d = idx_q + IW'(1);
               if (idx_q == IW'(NUM_RESETS - 1)) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         RUN: begin
            if (!lock_s) loss = 1'b1;
         end
         default: state_d = WAIT_LOCK;
      endcase

      if (clear_lost) begin
         lost_d = 1'b0;
         cnt_d  = 8'd0;
      end

      // Loss overrides a same-cycle clear, so the event is never dropped.
      if (loss) begin
         state_d = WAIT_LOCK;
         rst_d   = '0;
         ready_d = 1'b0;
         lost_d  = 1'b1;
         if (clear_lost)         cnt_d = 8'd1;
         else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
         else                     cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_LOCK;
         sync_q  <= '0;
         stab_q  <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
         lost_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         stab_q  <= stab_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         lost_q  <= lost_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rst_out_n  = rst_q;
   assign ready      = ready_q;
   assign lock_lost  = lost_q;
   assign lost_count = cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: fixed edge tables, hand-timed corner sequences and
// randomized lock/clear traffic against a run-length model of the sequencing rules.
module tb_pll_reset_sequencer;

   localparam int SS  = 2;
   localparam int LS  = 8;
   localparam int NR  = 3;
   localparam int GAP = 4;

   logic          clk_in = 1'b0;
   logic          reset_n = 1'b1;
   logic          pll_locked = 1'b0;
   logic          clear_lost = 1'b0;
   logic [NR-1:0] rst_out_n;
   logic          ready;
   logic          lock_lost;
   logic [7:0]    lost_count;
   logic [1:0]    dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_no = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES       (SS),
      .LOCK_STABLE_CYCLES(LS),
      .NUM_RESETS        (NR),
      .STAGE_GAP_CYCLES  (GAP)
   ) dut (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .pll_locked(pll_locked),
      .clear_lost(clear_lost),
      .rst_out_n (rst_out_n),
      .ready     (ready),
      .lock_lost (lock_lost),
      .lost_count(lost_count),
      .dbg_state (dbg_state)
   );

   always #5 clk_in = ~clk_in;

   // Model: m_h counts consecutive edges on which the sequencer saw lock high.
   // Bit k is released once m_h reaches 1+LS+(k+1)*GAP; a drop after m_h reached
   // 1+LS (release phase entered) is a counted loss.
   int         m_h;
   int         m_ev;
   logic       m_lost;
   logic [7:0] m_cnt;
   logic       lk_q[$];

   task automatic model_reset();
      lk_q.delete();
      for (int i = 0; i < SS; i++) lk_q.push_back(1'b0);
      m_h    = 0;
      m_ev   = 0;
      m_lost = 1'b0;
      m_cnt  = 8'd0;
   endtask

   task automatic model_step(input logic lk, input logic clr);
      logic l;
      logic lost_now;
      l = lk_q.pop_front();
      lk_q.push_back(lk);
      lost_now = !l && (m_h >= 1 + LS);
      if (l) begin
         if (m_h < 100000) m_h++;
      end else begin
         m_h = 0;
      end
      if (lost_now) begin
         m_ev++;
         m_lost = 1'b1;
         if (clr)                m_cnt = 8'd1;
         else if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
      end else if (clr) begin
         m_lost = 1'b0;
         m_cnt  = 8'd0;
      end
   endtask

   function automatic logic [NR-1:0] m_rst();
      logic [NR-1:0] r;
      for (int k = 0; k < NR; k++) r[k] = (m_h >= 1 + LS + (k + 1) * GAP);
      return r;
   endfunction

   function automatic logic m_rdy();
      return (m_h >= 1 + LS + NR * GAP);
   endfunction

   task automatic check_out(input string name, input logic [NR-1:0] e_rst, input logic e_rdy,
                            input logic e_lost, input logic [7:0] e_cnt);
      n_tests++;
      if (rst_out_n !== e_rst || ready !== e_rdy || lock_lost !== e_lost || lost_count !== e_cnt) begin
         n_fail++;
         $display("FAIL %s edge=%0d: got rst=%b rdy=%b lost=%b cnt=%0d, want rst=%b rdy=%b lost=%b cnt=%0d",
                  name, edge_no, rst_out_n, ready, lock_lost, lost_count, e_rst, e_rdy, e_lost, e_cnt);
      end
   endtask

   task automatic tick(input logic lk, input logic clr);
      pll_locked = lk;
      clear_lost = clr;
      @(posedge clk_in);
      model_step(lk, clr);
      #1;
      edge_no++;
      check_out("model", m_rst(), m_rdy(), m_lost, m_cnt);
      clear_lost = 1'b0;
   endtask

   // Asserts reset away from any clock edge and checks outputs before the next edge.
   task automatic apply_reset(input logic lk);
      pll_locked = lk;
      clear_lost = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check_out("async_reset", '0, 1'b0, 1'b0, 8'd0);
      n_tests++;
      if (dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d, want 0", dbg_state);
      end
      model_reset();
      repeat (2) @(posedge clk_in);
      #1 reset_n = 1'b1;
      edge_no = 0;
   endtask

   typedef struct {
      int            e;
      logic [NR-1:0] rst;
      logic          rdy;
      logic          lost;
      logic [7:0]    cnt;
   } vec_t;

   vec_t tbl [15];

   initial begin
      int   ti;
      int   hi;
      int   lo;
      logic seen_b1;

      // Clean lock, loss in RUN at edge 40, relock after edge 50.
      tbl = '{
         '{1,  3'b000, 1'b0, 1'b0, 8'd0},
         '{14, 3'b000, 1'b0, 1'b0, 8'd0},
         '{15, 3'b001, 1'b0, 1'b0, 8'd0},
         '{18, 3'b001, 1'b0, 1'b0, 8'd0},
         '{19, 3'b011, 1'b0, 1'b0, 8'd0},
         '{22, 3'b011, 1'b0, 1'b0, 8'd0},
         '{23, 3'b111, 1'b1, 1'b0, 8'd0},
         '{40, 3'b111, 1'b1, 1'b0, 8'd0},
         '{42, 3'b111, 1'b1, 1'b0, 8'd0},
         '{43, 3'b000, 1'b0, 1'b1, 8'd1},
         '{64, 3'b000, 1'b0, 1'b1, 8'd1},
         '{65, 3'b001, 1'b0, 1'b1, 8'd1},
         '{69, 3'b011, 1'b0, 1'b1, 8'd1},
         '{72, 3'b011, 1'b0, 1'b1, 8'd1},
         '{73, 3'b111, 1'b1, 1'b1, 8'd1}
      };

      apply_reset(1'b1);
      ti = 0;
      for (int e = 1; e <= 75; e++) begin
         tick((e <= 40) || (e >= 51), 1'b0);
         if (ti < 15 && tbl[ti].e == edge_no) begin
            check_out($sformatf("clean_e%0d", tbl[ti].e), tbl[ti].rst, tbl[ti].rdy, tbl[ti].lost, tbl[ti].cnt);
            ti++;
         end
      end

      // Reset mid-RELEASE, then a fresh sequence with identical edge numbers.
      apply_reset(1'b1);
      for (int e = 1; e <= 17; e++) tick(1'b1, 1'b0);
      apply_reset(1'b1);
      for (int e = 1; e <= 23; e++) begin
         tick(1'b1, 1'b0);
         if (edge_no == 15) check_out("rerun_e15", 3'b001, 1'b0, 1'b0, 8'd0);
         if (edge_no == 19) check_out("rerun_e19", 3'b011, 1'b0, 1'b0, 8'd0);
         if (edge_no == 23) check_out("rerun_e23", 3'b111, 1'b1, 1'b0, 8'd0);
      end

      // Three-cycle glitch during STABLE: qualification restarts at edge 12.
      apply_reset(1'b1);
      for (int e = 1; e <= 32; e++) begin
         tick(!(e >= 7 && e <= 9), 1'b0);
         if (edge_no == 23) check_out("glitch_e23", 3'b000, 1'b0, 1'b0, 8'd0);
         if (edge_no == 24) check_out("glitch_e24", 3'b001, 1'b0, 1'b0, 8'd0);
         if (edge_no == 32) check_out("glitch_e32", 3'b111, 1'b1, 1'b0, 8'd0);
      end

      // Loss after bit 0 released: everything re-asserts, bit 1 never seen.
      apply_reset(1'b1);
      seen_b1 = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         tick(e <= 16, 1'b0);
         seen_b1 = seen_b1 | rst_out_n[1];
         if (edge_no == 18) check_out("midrel_e18", 3'b001, 1'b0, 1'b0, 8'd0);
         if (edge_no == 19) check_out("midrel_e19", 3'b000, 1'b0, 1'b1, 8'd1);
      end
      n_tests++;
      if (seen_b1 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrel_bit1: got released=%b, want 0", seen_b1);
      end

      // Random lock runs until well past 255 counted losses.
      while (m_ev < 260) begin
         hi = $urandom_range(1, 30);
         lo = $urandom_range(1, 5);
         repeat (hi) tick(1'b1, 1'b0);
         repeat (lo) tick(1'b0, 1'b0);
      end
      repeat (3) tick(1'b0, 1'b0);
      check_out("saturate", 3'b000, 1'b0, 1'b1, 8'd255);

      tick(1'b0, 1'b1);
      check_out("clear", 3'b000, 1'b0, 1'b0, 8'd0);

      repeat (20) tick(1'b1, 1'b0);
      check_out("pre_clr_loss", 3'b011, 1'b0, 1'b0, 8'd0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      check_out("clr_vs_loss", 3'b000, 1'b0, 1'b1, 8'd1);

      // Mixed random lock runs and random clear pulses.
      for (int r = 0; r < 120; r++) begin
         hi = $urandom_range(1, 30);
         lo = $urandom_range(1, 5);
         repeat (hi) tick(1'b1, $urandom_range(0, 15) == 0);
         repeat (lo) tick(1'b0, $urandom_range(0, 7) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
